mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single-ported byte-addressed data memory between the instruction-fetch (IF) and load/store (DM) requesters.
//   Arbitrates, latches one request, and drives the memory strobes/offset/sign controls for exactly one cycle.
//   Registers the read data and returns a one-cycle done pulse (with error flag) to the winning requester.
//   Sits between the core pipeline and the memory; the pipeline stalls while its done is pending.
// PARAMETERS
//   ADDR_W    32    address width of requester and memory address ports
//   MEM_BYTES 4096  memory size in bytes; any access touching a byte >= MEM_BYTES is an error
//   MAX_WAIT  4     consecutive DM grants while IF waits before IF is forced to win (>=1)
// PORTS
//   clk          in   1       clock; all state updates on rising edge
//   rst          in   1       synchronous, active-high reset
//   if_req       in   1       fetch request; held high with stable if_addr until if_done
//   if_addr      in   ADDR_W  fetch byte address (always word access, unsigned ignored)
//   if_done      out  1       one-cycle pulse: if_rdata/if_err valid
//   if_rdata     out  32      fetched word
//   if_err       out  1       fetch misaligned/out of range (qualified by if_done)
//   dm_req       in   1       load/store request; held high with stable fields until dm_done
//   dm_we        in   1       1=store, 0=load
//   dm_addr      in   ADDR_W  data byte address
//   dm_size      in   3       100=word, 010=half, 001=byte; other codes are errors
//   dm_unsigned  in   1       load zero-extend (1) / sign-extend (0)
//   dm_wdata     in   32      store data, low bytes used for half/byte
//   dm_done      out  1       one-cycle pulse: dm_rdata/dm_err valid
//   dm_rdata     out  32      load data (0 for stores)
//   dm_err       out  1       data access misaligned/out of range/bad size (qualified by dm_done)
//   mem_read     out  1       memory read strobe
//   mem_write    out  1       memory write strobe
//   mem_offset   out  3       memory size code (same encoding as dm_size)
//   mem_unsigned out  1       memory load extension control
//   mem_addr     out  ADDR_W  memory byte address
//   mem_wdata    out  32      memory write data
//   mem_rdata    in   32      memory read data, combinational from mem_* controls
//   busy         out  1       1 whenever state != IDLE
// BEHAVIOUR
//   Reset: state=IDLE, wait_cnt=0; all outputs 0 (strobes, done, err, rdata, mem_* buses).
//   FSM IDLE -> ACCESS -> RESP -> IDLE; error path IDLE -> RESP (no ACCESS, no strobes).
//   IDLE: if any req, pick winner, latch owner/addr/size/we/unsigned/wdata, check legality:
//     word needs addr[1:0]==0, half needs addr[0]==0, size in {100,010,001}, addr+bytes-1 < MEM_BYTES.
//     Legal -> ACCESS; illegal -> RESP with err=1.
//   Arbitration: DM wins ties unless wait_cnt==MAX_WAIT, then IF wins. Single requester always wins.
//     wait_cnt: +1 on DM grant while if_req=1 (saturate at MAX_WAIT); cleared on IF grant.
//   ACCESS (exactly 1 cycle): mem_read=~we, mem_write=we, mem_addr/offset/unsigned/wdata from latch;
//     IF owner drives offset=100, unsigned=1, read only. mem_rdata captured into rdata reg at edge ending ACCESS.
//   RESP (1 cycle): owner's done=1, err per check, rdata from reg (0 for store or err); other port's done=0.
//   mem_* outputs are 0 in every cycle except ACCESS; at most one strobe high at any time.
//   Latency: req sampled at edge k (IDLE) -> strobes in cycle k+1 -> done in cycle k+2; error done in cycle k+1.
//   Throughput: one access per 3 cycles; a req held after its done re-arbitrates as a new access.
//   Requests arriving outside IDLE are not sampled; loser simply waits with req high.
//   Inputs changing before done (protocol violation) do not affect the latched access.
//   rst mid-operation: next state IDLE, outputs 0, no done for the aborted access; a write strobed
//     in ACCESS before the reset edge is committed. Requester re-presents after rst falls.
// TESTING
//   rst 3 cycles -> all outputs 0, busy=0; if_req=1 addr=0 -> mem_read in cycle 1, if_done cycle 2, if_rdata=100 (mem[0..3]=0x64).
//   dm store word 0xDEADBEEF @8, then load half signed @10 -> dm_rdata=0xFFFFDEAD; unsigned byte @11 -> 0x000000DE.
//   dm load word @2 -> dm_err=1 in cycle after req, mem_read/mem_write never high; size 011 @0 -> dm_err=1.
//   if_req and dm_req held high continuously, MAX_WAIT=4 -> grants DM,DM,DM,DM,IF,DM... ; no two strobes together.
//   dm word access @4094 (MEM_BYTES=4096) -> dm_err=1; byte @4095 -> legal, dm_done without err.
//   rst asserted during ACCESS of store @0 -> no dm_done, FSM IDLE next cycle, later load @0 returns stored value.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported data memory between instruction fetch and load/store,
// issuing one registered memory access per grant and a one-cycle done pulse to the winner.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MEM_BYTES = 4096,
    parameter int unsigned MAX_WAIT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [2:0]        dm_size,
    input  logic              dm_unsigned,
    input  logic [31:0]       dm_wdata,
    output logic              dm_done,
    output logic [31:0]       dm_rdata,
    output logic              dm_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [2:0]        mem_offset,
    output logic              mem_unsigned,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    localparam int unsigned EXT_W = ADDR_W + 1;
    localparam logic [2:0]  SZ_WORD = 3'b100;
    localparam logic [2:0]  SZ_HALF = 3'b010;
    localparam logic [2:0]  SZ_BYTE = 3'b001;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              owner_if_q, owner_if_d;
    logic              we_q, we_d;
    logic              if_done_q, if_done_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic              if_err_q, if_err_d;
    logic              dm_done_q, dm_done_d;
    logic [31:0]       dm_rdata_q, dm_rdata_d;
    logic              dm_err_q, dm_err_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [2:0]        mem_offset_q, mem_offset_d;
    logic              mem_unsigned_q, mem_unsigned_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;

    logic              grant_if_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [2:0]        sel_size_c;
    logic              sel_we_c;
    logic              sel_uns_c;
    logic [31:0]       sel_wdata_c;
    logic [2:0]        span_c;
    logic              size_ok_c;
    logic              align_ok_c;
    logic              range_ok_c;
    logic              legal_c;
    logic [EXT_W-1:0]  last_byte_c;

    // Winner selection and legality of the winner's access; extra address bit keeps the range check overflow-free
    always_comb begin
        grant_if_c = if_req && (!dm_req || (wait_cnt_q == CNT_W'(MAX_WAIT)));
        if (grant_if_c) begin
            sel_addr_c  = if_addr;
            sel_size_c  = SZ_WORD;
            sel_we_c    = 1'b0;
            sel_uns_c   = 1'b1;
            sel_wdata_c = 32'd0;
        end else begin
            sel_addr_c  = dm_addr;
            sel_size_c  = dm_size;
            sel_we_c    = dm_we;
            sel_uns_c   = dm_unsigned;
            sel_wdata_c = dm_wdata;
        end
        span_c     = 3'd0;
        size_ok_c  = 1'b1;
        align_ok_c = 1'b1;
        case (sel_size_c)
            SZ_WORD: begin
                span_c     = 3'd3;
                align_ok_c = (sel_addr_c[1:0] == 2'b00);
            end
            SZ_HALF: begin
                span_c     = 3'd1;
                align_ok_c = !sel_addr_c[0];
            end
            SZ_BYTE: span_c = 3'd0;
            default: size_ok_c = 1'b0;
        endcase
        last_byte_c = EXT_W'(sel_addr_c) + EXT_W'(span_c);
        range_ok_c  = (last_byte_c < EXT_W'(MEM_BYTES));
        legal_c     = size_ok_c && align_ok_c && range_ok_c;
    end

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        owner_if_d     = owner_if_q;
        we_d           = we_q;
        if_done_d      = 1'b0;
        if_rdata_d     = 32'd0;
        if_err_d       = 1'b0;
        dm_done_d      = 1'b0;
        dm_rdata_d     = 32'd0;
        dm_err_d       = 1'b0;
        mem_read_d     = 1'b0;
        mem_write_d    = 1'b0;
        mem_offset_d   = 3'd0;
        mem_unsigned_d = 1'b0;
        mem_addr_d     = '0;
        mem_wdata_d    = 32'd0;
        case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    owner_if_d = grant_if_c;
                    we_d       = sel_we_c;
                    if (grant_if_c) begin
                        wait_cnt_d = '0;
                    end else if (if_req && (wait_cnt_q != CNT_W'(MAX_WAIT))) begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                    if (legal_c) begin
                        state_d        = ACCESS;
                        mem_read_d     = !sel_we_c;
                        mem_write_d    = sel_we_c;
                        mem_offset_d   = sel_size_c;
                        mem_unsigned_d = sel_uns_c;
                        mem_addr_d     = sel_addr_c;
                        mem_wdata_d    = sel_wdata_c;
                    end else begin
                        // Illegal accesses skip the memory and answer immediately
                        state_d = RESP;
                        if (grant_if_c) begin
                            if_done_d = 1'b1;
                            if_err_d  = 1'b1;
                        end else begin
                            dm_done_d = 1'b1;
                            dm_err_d  = 1'b1;
                        end
                    end
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (owner_if_q) begin
                    if_done_d  = 1'b1;
                    if_rdata_d = mem_rdata;
                end else begin
                    dm_done_d  = 1'b1;
                    dm_rdata_d = we_q ? 32'd0 : mem_rdata;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            wait_cnt_q     <= '0;
            owner_if_q     <= 1'b0;
            we_q           <= 1'b0;
            if_done_q      <= 1'b0;
            if_rdata_q     <= 32'd0;
            if_err_q       <= 1'b0;
            dm_done_q      <= 1'b0;
            dm_rdata_q     <= 32'd0;
            dm_err_q       <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_offset_q   <= 3'd0;
            mem_unsigned_q <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= 32'd0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            owner_if_q     <= owner_if_d;
            we_q           <= we_d;
            if_done_q      <= if_done_d;
            if_rdata_q     <= if_rdata_d;
            if_err_q       <= if_err_d;
            dm_done_q      <= dm_done_d;
            dm_rdata_q     <= dm_rdata_d;
            dm_err_q       <= dm_err_d;
            mem_read_q     <= mem_read_d;
            mem_write_q    <= mem_write_d;
            mem_offset_q   <= mem_offset_d;
            mem_unsigned_q <= mem_unsigned_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            busy_q         <= busy_d;
        end
    end

    assign if_done      = if_done_q;
    assign if_rdata     = if_rdata_q;
    assign if_err       = if_err_q;
    assign dm_done      = dm_done_q;
    assign dm_rdata     = dm_rdata_q;
    assign dm_err       = dm_err_q;
    assign mem_read     = mem_read_q;
    assign mem_write    = mem_write_q;
    assign mem_offset   = mem_offset_q;
    assign mem_unsigned = mem_unsigned_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte memory with combinational read, directed and random
// accesses checked against a byte-array reference model and an arbitration counter model.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned MEM_BYTES = 4096;
    localparam int unsigned MAX_WAIT  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [31:0]       if_rdata;
    logic              if_err;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [2:0]        dm_size;
    logic              dm_unsigned;
    logic [31:0]       dm_wdata;
    logic              dm_done;
    logic [31:0]       dm_rdata;
    logic              dm_err;
    logic              mem_read;
    logic              mem_write;
    logic [2:0]        mem_offset;
    logic              mem_unsigned;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_err(if_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_size(dm_size),
        .dm_unsigned(dm_unsigned), .dm_wdata(dm_wdata),
        .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_err(dm_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_offset(mem_offset),
        .mem_unsigned(mem_unsigned), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    function automatic logic [7:0] pat(input int i);
        if (i == 0) return 8'h64;
        if (i < 4) return 8'h00;
        return 8'(i * 37 + 11);
    endfunction

    // Memory model: little-endian bytes, extension done by the memory, write on the clock edge
    logic [7:0] mem [MEM_BYTES];
    logic       preload;
    logic [7:0] b0, b1, b2, b3;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] <= pat(i);
        end else if (mem_write) begin
            mem[12'(mem_addr)] <= mem_wdata[7:0];
            if (mem_offset != 3'b001) mem[12'(mem_addr + 1)] <= mem_wdata[15:8];
            if (mem_offset == 3'b100) begin
                mem[12'(mem_addr + 2)] <= mem_wdata[23:16];
                mem[12'(mem_addr + 3)] <= mem_wdata[31:24];
            end
        end
    end

    always_comb begin
        b0 = mem[12'(mem_addr)];
        b1 = mem[12'(mem_addr + 1)];
        b2 = mem[12'(mem_addr + 2)];
        b3 = mem[12'(mem_addr + 3)];
        mem_rdata = 32'd0;
        if (mem_read) begin
            case (mem_offset)
                3'b100:  mem_rdata = {b3, b2, b1, b0};
                3'b010:  mem_rdata = mem_unsigned ? {16'd0, b1, b0} : {{16{b1[7]}}, b1, b0};
                3'b001:  mem_rdata = mem_unsigned ? {24'd0, b0} : {{24{b0[7]}}, b0};
                default: mem_rdata = 32'd0;
            endcase
        end
    end

    // Reference model
    logic [7:0] ref_mem [MEM_BYTES];

    function automatic int nbytes(input logic [2:0] size);
        case (size)
            3'b100:  return 4;
            3'b010:  return 2;
            3'b001:  return 1;
            default: return 0;
        endcase
    endfunction

    function automatic bit legal(input logic [31:0] addr, input logic [2:0] size);
        int n = nbytes(size);
        if (n == 0) return 1'b0;
        if ((longint'(addr) % n) != 0) return 1'b0;
        return (longint'(addr) + n) <= longint'(MEM_BYTES);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] size, input bit uns);
        int n = nbytes(size);
        longint v = 0;
        for (int k = 0; k < n; k++) v = v + (longint'(ref_mem[int'(addr) + k]) << (8 * k));
        if (!uns && v[8 * n - 1]) v = v - (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wd);
        for (int k = 0; k < nbytes(size); k++) ref_mem[int'(addr) + k] = wd[8 * k +: 8];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock; samples on the falling edge and checks memory-bus invariants every cycle
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        chk("one_strobe", 32'(mem_read & mem_write), 32'd0);
        if (!(mem_read || mem_write))
            chk("mem_bus_idle", mem_addr | mem_wdata | {28'd0, mem_offset, mem_unsigned}, 32'd0);
    endtask

    task automatic txn(input bit is_if, input bit we, input logic [31:0] addr, input logic [2:0] size,
                       input bit uns, input logic [31:0] wd, input string tag, output logic [31:0] rd);
        logic [2:0]  sz      = is_if ? 3'b100 : size;
        bit          exp_err = !legal(addr, sz);
        logic [31:0] exp_rd  = (exp_err || (we && !is_if)) ? 32'd0 : ref_load(addr, sz, is_if ? 1'b1 : uns);
        int          cyc     = 0;
        bit          got     = 0;
        bit          strobed = 0;
        rd = 32'd0;
        if (is_if) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_size = size; dm_unsigned = uns; dm_wdata = wd;
        end
        while (!got && cyc < 8) begin
            tick();
            cyc++;
            strobed = strobed | mem_read | mem_write;
            if (cyc == 1 && !exp_err) begin
                chk({tag, "_rd_strobe"}, 32'(mem_read), 32'(!(we && !is_if)));
                chk({tag, "_wr_strobe"}, 32'(mem_write), 32'(we && !is_if));
                chk({tag, "_mem_addr"}, mem_addr, addr);
                chk({tag, "_mem_offset"}, 32'(mem_offset), 32'(sz));
                if (we && !is_if) chk({tag, "_mem_wdata"}, mem_wdata, wd);
            end
            if (cyc == 1) begin
                // Disturb the request fields; the latched access must not change
                if_addr = ~addr; dm_addr = ~addr; dm_wdata = ~wd; dm_size = 3'($urandom); dm_unsigned = !uns;
            end
            if (is_if ? if_done : dm_done) begin
                got = 1;
                rd  = is_if ? if_rdata : dm_rdata;
                chk({tag, "_err"}, 32'(is_if ? if_err : dm_err), 32'(exp_err));
                chk({tag, "_rdata"}, rd, exp_rd);
                chk({tag, "_other_done"}, 32'(is_if ? dm_done : if_done), 32'd0);
            end
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        chk({tag, "_latency"}, 32'(cyc), exp_err ? 32'd1 : 32'd2);
        chk({tag, "_strobed"}, 32'(strobed), 32'(!exp_err));
        if (!exp_err && we && !is_if) ref_store(addr, sz, wd);
        if_req = 1'b0;
        dm_req = 1'b0;
        tick();
        chk({tag, "_done_pulse"}, 32'(if_done | dm_done), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            preload = 1'b0;
            chk("rst_flags", 32'({if_done, if_err, dm_done, dm_err, mem_read, mem_write, busy}), 32'd0);
            chk("rst_buses", if_rdata | dm_rdata | mem_addr | mem_wdata, 32'd0);
        end
        rst = 1'b0;
    endtask

    logic [2:0] size_codes [9] = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001, 3'b011, 3'b000, 3'b111};

    initial begin
        logic [31:0] rd;
        logic [31:0] ra;
        int          wc;
        int          gap;
        bit          exp_if;
        bit          got;
        rst = 1'b1; preload = 1'b1;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_size = 3'b100; dm_unsigned = 1'b0; dm_wdata = '0;
        for (int i = 0; i < int'(MEM_BYTES); i++) ref_mem[i] = pat(i);
        @(negedge clk);
        do_reset();

        txn(1'b1, 1'b0, 32'd0, 3'b100, 1'b1, 32'd0, "if_fetch0", rd);
        chk("if_fetch0_const", rd, 32'd100);
        txn(1'b1, 1'b0, 32'd2, 3'b100, 1'b1, 32'd0, "if_misalign", rd);
        txn(1'b1, 1'b0, 32'd4096, 3'b100, 1'b1, 32'd0, "if_range", rd);

        txn(1'b0, 1'b1, 32'd8, 3'b100, 1'b0, 32'hDEADBEEF, "st_word8", rd);
        txn(1'b0, 1'b0, 32'd10, 3'b010, 1'b0, 32'd0, "ld_half10", rd);
        chk("ld_half10_const", rd, 32'hFFFFDEAD);
        txn(1'b0, 1'b0, 32'd11, 3'b001, 1'b1, 32'd0, "ld_byte11", rd);
        chk("ld_byte11_const", rd, 32'h000000DE);
        txn(1'b0, 1'b0, 32'd2, 3'b100, 1'b0, 32'd0, "ld_word2", rd);
        txn(1'b0, 1'b0, 32'd0, 3'b011, 1'b0, 32'd0, "bad_size", rd);
        txn(1'b0, 1'b0, 32'd4094, 3'b100, 1'b0, 32'd0, "word4094", rd);
        txn(1'b0, 1'b0, 32'd4095, 3'b001, 1'b1, 32'd0, "byte4095", rd);
        txn(1'b0, 1'b1, 32'd4094, 3'b010, 1'b0, 32'h0000A5C3, "st_half4094", rd);
        txn(1'b0, 1'b0, 32'd4094, 3'b010, 1'b0, 32'd0, "ld_half4094", rd);

        // Reset while a store is in its memory cycle: the store lands, the done never comes
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'd0; dm_size = 3'b100; dm_wdata = 32'h12345678;
        tick();
        chk("rst_mid_wr_strobe", 32'(mem_write), 32'd1);
        rst = 1'b1;
        tick();
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_no_done", 32'(dm_done), 32'd0);
        ref_store(32'd0, 3'b100, 32'h12345678);
        dm_req = 1'b0; rst = 1'b0;
        tick();
        chk("rst_mid_no_late_done", 32'(dm_done | busy), 32'd0);
        txn(1'b0, 1'b0, 32'd0, 3'b100, 1'b0, 32'd0, "ld_after_rst", rd);
        chk("ld_after_rst_const", rd, 32'h12345678);

        // Both requesters held high: fetch is forced through after MAX_WAIT load/store grants
        do_reset();
        wc = 0; gap = 0;
        if_req = 1'b1; if_addr = 32'd0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'd16; dm_size = 3'b100; dm_unsigned = 1'b0;
        for (int g = 0; g < 12; g++) begin
            exp_if = (wc == int'(MAX_WAIT));
            wc = exp_if ? 0 : ((wc < int'(MAX_WAIT)) ? wc + 1 : wc);
            got = 0; gap = 0;
            while (!got && gap < 6) begin
                tick();
                gap++;
                chk("arb_both_done", 32'(if_done & dm_done), 32'd0);
                if (if_done || dm_done) got = 1;
            end
            chk("arb_done_seen", 32'(got), 32'd1);
            chk("arb_grant_if", 32'(if_done), 32'(exp_if));
            chk("arb_gap", 32'(gap), (g == 0) ? 32'd2 : 32'd3);
            chk("arb_rdata", exp_if ? if_rdata : dm_rdata, exp_if ? ref_load(32'd0, 3'b100, 1'b1)
                                                                  : ref_load(32'd16, 3'b100, 1'b0));
        end
        if_req = 1'b0; dm_req = 1'b0;
        tick(); tick();

        // Random single-requester traffic concentrated near the alignment and range boundaries
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 3))
                0:       ra = 32'($urandom_range(0, MEM_BYTES - 1));
                1:       ra = 32'($urandom_range(MEM_BYTES - 8, MEM_BYTES + 3));
                2:       ra = 32'($urandom_range(0, 15));
                default: ra = $urandom;
            endcase
            if ($urandom_range(0, 4) == 0)
                txn(1'b1, 1'b0, ra & 32'hFFFF_FFFD, 3'b100, 1'b1, 32'd0, "rnd_if", rd);
            else
                txn(1'b0, 1'($urandom), ra, size_codes[$urandom_range(0, 8)], 1'($urandom), $urandom, "rnd_dm", rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
